fetch_unit: RTL
===============

# fetch_unit

Instruction fetch and decode stage for the SCIC CPU. Owns the program counter, drives the instruction ROM's address and chip-select, and latches each 32-bit word into an instruction register. Resolves branches and NOPs locally, and hands every other instruction (opcode + 16-bit operand) to the execute stage over a valid/ready handshake.

## Interface
- `ADDR_WIDTH`, default 5: ROM address width. The PC wraps at 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 32: ROM word width. Opcode is bits [31:28]; operand is bits [15:0].
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rom_address`  out  ADDR_WIDTH  word address presented to the ROM.
- `rom_cs`  out  1  ROM chip-select; high only in FETCH.
- `rom_data`  in  DATA_WIDTH  ROM word (combinational, valid in the same cycle as address).
- `instr_valid`  out  1  issued instruction available.
- `instr_ready`  in  1  execute stage accepts the instruction.
- `opcode`  out  4  issued opcode (1–7, 9).
- `operand`  out  16  issued operand.
- `pc`  out  ADDR_WIDTH  current PC, for debug.
- `illegal`  out  1  sticky flag: an opcode in 0xA–0xF was fetched.

## Operation
- State machine with three states: FETCH, DECODE, ISSUE.
- **FETCH**
  - `rom_cs`=1 and `rom_address`=PC.
  - On the clock edge: IR ← `rom_data`, PC ← PC+1 (modulo 2^ADDR_WIDTH, so 31→0), next state DECODE.
- **DECODE**: action depends on IR[31:28].
  - 8 (BR): PC ← IR[ADDR_WIDTH-1:0]; operand bits above ADDR_WIDTH are ignored; next FETCH.
  - 0 (NOP): no issue; next FETCH.
  - 0xA–0xF: `illegal` ← 1; instruction is dropped; next FETCH.
  - 1–7, 9: `opcode` ← IR[31:28], `operand` ← IR[15:0], `instr_valid` ← 1; next ISSUE.
- **ISSUE**
  - Hold `instr_valid`, `opcode` and `operand` stable while `instr_ready`=0.
  - When `instr_valid`&&`instr_ready` at a clock edge: `instr_valid` ← 0, next FETCH.
- `illegal` is cleared only by reset.
- Fetch unit never issues opcode 0, 8 or illegal codes.

## Timing
- Reset values:
  - `rom_address`=0, `rom_cs`=0, `instr_valid`=0.
  - `opcode`=0, `operand`=0, `pc`=0, `illegal`=0.
  - IR=0, state=FETCH.
- First cycle after reset deasserts: FETCH of address 0.
- All outputs are registered, except `rom_cs` and `rom_address`, which are decoded from state/PC.
- Latency with `instr_ready` held high:
  - Issued instruction: 3 cycles per instruction (FETCH, DECODE, ISSUE). `instr_valid` rises 2 cycles after FETCH begins.
  - Branch or NOP: 2 cycles. A branch target is fetched in the cycle immediately after DECODE.
- Back-pressure: each cycle `instr_ready`=0 extends ISSUE by one cycle. PC does not advance and the ROM is not selected.
- `instr_ready` asserted outside ISSUE is ignored.
- Reset mid-operation wins over any transition:
  - An instruction in ISSUE is dropped (`instr_valid`=0 the next cycle).
  - PC returns to 0.
- BR to the branch's own address gives an endless FETCH/DECODE loop; this is legal.

## Structure
- Shared package `scic_pkg` holds:
  - Opcode localparams: OP_NOP=0, OP_ADD=1, OP_SHL=2, OP_SHR=3, OP_LI=4, OP_LD=5, OP_OR=6, OP_ST=7, OP_BR=8, OP_AND=9.
  - Field positions (OPC_MSB=31, OPC_LSB=28, OPR_MSB=15).
  - Fetch-state enum.
- Sub-module `opcode_classifier` (combinational): 4-bit opcode in; is_branch/is_nop/is_illegal/is_issue out. It is reused later by the execute stage.

## Test plan
- **Straight-line issue**: reset, then ROM word 0 = 0x4000_000F, `instr_ready`=1.
  - Required: `instr_valid` high in cycle 3 with `opcode`=4, `operand`=0x000F.
  - Next FETCH at address 1.
- **Back-pressure**: `instr_ready`=0 for 5 cycles during ISSUE of 0x7000_005F.
  - Required: `opcode`=7 and `operand`=0x005F held stable, `rom_cs`=0, `pc` unchanged.
  - Required: accepted on the first cycle `instr_ready`=1.
- **Branch**: word 0x15 = 0x8000_0000.
  - Required: no `instr_valid` pulse.
  - Required: the next `rom_address` is 0, 2 cycles after fetching 0x15.
- **NOP and illegal**:
  - Word 0x17 = 0 → skipped, next fetch at 0x18.
  - Word 0xA000_0001 → `illegal`=1 sticky, no issue.
- **PC wrap**: with address 31 holding 0x1000_0001, it issues, and the next fetch address is 0.
- **Reset in ISSUE**: assert `reset` while `instr_valid`=1 and `instr_ready`=0.
  - Required: the next cycle has `instr_valid`=0, `pc`=0, `illegal`=0.
  - Required: the fetch after release is at address 0.

Source files
------------

// File: rtl/scic_pkg.sv
// Shared definitions for the SCIC CPU front end.
//   - Opcode encodings used by fetch and execute.
//   - Bit positions of the opcode and operand fields within an instruction word.
//   - Fetch-stage state encoding.
package scic_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SHL = 4'd2;
    localparam logic [3:0] OP_SHR = 4'd3;
    localparam logic [3:0] OP_LI  = 4'd4;
    localparam logic [3:0] OP_LD  = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_ST  = 4'd7;
    localparam logic [3:0] OP_BR  = 4'd8;
    localparam logic [3:0] OP_AND = 4'd9;

    // Lowest opcode of the reserved (illegal) range 0xA..0xF.
    localparam logic [3:0] OP_ILLEGAL_MIN = 4'hA;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int OPR_MSB = 15;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_ISSUE  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode classifier, shared by the fetch and execute stages.
// Ports:
//   opcode     in  4  opcode field of an instruction
//   is_branch  out 1  opcode is BR
//   is_nop     out 1  opcode is NOP
//   is_illegal out 1  opcode is in the reserved range 0xA..0xF
//   is_issue   out 1  opcode is an executable instruction (1..7, 9)
// Exactly one output is high for any opcode.
module opcode_classifier
    import scic_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_branch,
    output logic       is_nop,
    output logic       is_illegal,
    output logic       is_issue
);

    always_comb begin
        is_branch  = (opcode == OP_BR);
        is_nop     = (opcode == OP_NOP);
        is_illegal = (opcode >= OP_ILLEGAL_MIN);
        is_issue   = !(is_branch || is_nop || is_illegal);
    end

endmodule

// File: rtl/fetch_unit.sv
// SCIC instruction fetch/decode stage.
// Owns the PC, reads the instruction ROM, resolves branches and NOPs locally
// and hands executable instructions to the execute stage via valid/ready.
// Ports:
//   clk          in   1           clock, rising edge
//   reset        in   1           synchronous active-high reset
//   rom_address  out  ADDR_WIDTH  ROM word address (PC while fetching, else 0)
//   rom_cs       out  1           ROM chip-select, high only while fetching
//   rom_data     in   DATA_WIDTH  ROM word, combinational from rom_address
//   instr_valid  out  1           issued instruction available
//   instr_ready  in   1           execute stage accepts the instruction
//   opcode       out  4           issued opcode
//   operand      out  16          issued operand
//   pc           out  ADDR_WIDTH  current PC (debug)
//   illegal      out  1           sticky: a reserved opcode was fetched
module fetch_unit
    import scic_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic                  rom_cs,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [3:0]            opcode,
    output logic [15:0]           operand,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  illegal
);

    fetch_state_t          state_reg;
    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] ir_reg;
    logic                  valid_reg;
    logic [3:0]            opcode_reg;
    logic [15:0]           operand_reg;
    logic                  illegal_reg;

    logic is_branch;
    logic is_nop;
    logic is_illegal;
    logic is_issue;

    // Bits between the operand and opcode fields carry no meaning here.
    logic ir_unused;
    assign ir_unused = ^ir_reg[OPC_LSB-1:OPR_MSB+1];

    opcode_classifier u_classifier (
        .opcode     (ir_reg[OPC_MSB:OPC_LSB]),
        .is_branch  (is_branch),
        .is_nop     (is_nop),
        .is_illegal (is_illegal),
        .is_issue   (is_issue)
    );

    // The ROM is only selected while fetching; gating with reset keeps the
    // chip-select low for the whole reset period even though the state
    // register already sits in FETCH.
    always_comb begin
        rom_cs      = (state_reg == ST_FETCH) && !reset;
        rom_address = rom_cs ? pc_reg : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_FETCH;
            pc_reg      <= '0;
            ir_reg      <= '0;
            valid_reg   <= 1'b0;
            opcode_reg  <= '0;
            operand_reg <= '0;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    ir_reg    <= rom_data;
                    pc_reg    <= pc_reg + 1'b1;   // wraps naturally at 2^ADDR_WIDTH
                    state_reg <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (is_branch) begin
                        // Target bits above the PC width are ignored.
                        pc_reg    <= ir_reg[ADDR_WIDTH-1:0];
                        state_reg <= ST_FETCH;
                    end else if (is_illegal) begin
                        illegal_reg <= 1'b1;
                        state_reg   <= ST_FETCH;
                    end else if (is_issue) begin
                        opcode_reg  <= ir_reg[OPC_MSB:OPC_LSB];
                        operand_reg <= ir_reg[OPR_MSB:0];
                        valid_reg   <= 1'b1;
                        state_reg   <= ST_ISSUE;
                    end else if (is_nop) begin
                        state_reg <= ST_FETCH;
                    end else begin
                        state_reg <= ST_FETCH;
                    end
                end
                ST_ISSUE: begin
                    // Opcode/operand stay untouched until the handshake completes.
                    if (valid_reg && instr_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= ST_FETCH;
                    end
                end
                default: begin
                    state_reg <= ST_FETCH;
                end
            endcase
        end
    end

    assign instr_valid = valid_reg;
    assign opcode      = opcode_reg;
    assign operand     = operand_reg;
    assign pc          = pc_reg;
    assign illegal     = illegal_reg;

endmodule
